// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer that fetches one- and two-word
// instructions over a ready/valid program-memory port. It keeps a return-address
// stack for CALL/RET and drives one-cycle ctl_* strobes to the ALU/IO datapath.
module seq_control_unit #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              prog_mem_req,
  output logic [ADDR_W-1:0] prog_mem_addr,
  input  logic              prog_mem_valid,
  input  logic [WIDTH-1:0]  prog_mem_data,
  output logic [WIDTH-1:0]  arg,
  input  logic              alu_is_zero,
  output logic              ctl_hlt,
  output logic              ctl_arg,
  output logic              ctl_nad,
  output logic              ctl_shl,
  output logic              ctl_shr,
  output logic              ctl_acc,
  output logic              ctl_out,
  output logic              ctl_read,
  output logic              ctl_write,
  output logic              halted,
  output logic              err
);

  // sp must be able to represent a full stack, so it needs one extra count value
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [3:0] OP_HLT  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JMZ  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;

  typedef enum logic [1:0] {
    S_FETCH,
    S_FETCH_ARG,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [3:0]        inst;
  logic [8:0]        strobes;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] stack [0:(1<<IDX_W)-1];

  // Opcodes whose following word is an argument
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == 4'h2) || (op == 4'h8) || (op == 4'h9) ||
           (op == OP_JMP) || (op == OP_JMZ) || (op == OP_CALL);
  endfunction

  // Strobe vector ordered {hlt, arg, nad, shl, shr, acc, out, read, write}
  function automatic logic [8:0] strobe_of(input logic [3:0] op);
    logic [8:0] s;
    s = '0;
    case (op)
      4'h1:    s = 9'b1_0000_0000;
      4'h2:    s = 9'b0_1000_0000;
      4'h3:    s = 9'b0_0100_0000;
      4'h4:    s = 9'b0_0010_0000;
      4'h5:    s = 9'b0_0001_0000;
      4'h6:    s = 9'b0_0000_1000;
      4'h7:    s = 9'b0_0000_0100;
      4'h8:    s = 9'b0_0000_0010;
      4'h9:    s = 9'b0_0000_0001;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign sp_dec        = sp - SP_W'(1);
  assign push_idx      = sp[IDX_W-1:0];
  assign pop_idx       = sp_dec[IDX_W-1:0];
  assign prog_mem_req  = (state == S_FETCH) || (state == S_FETCH_ARG);
  assign prog_mem_addr = pc;
  assign halted        = (state == S_HALT);

  assign {ctl_hlt, ctl_arg, ctl_nad, ctl_shl, ctl_shr,
          ctl_acc, ctl_out, ctl_read, ctl_write} = strobes;

  // Main sequencer: fetch, optional argument fetch, one execute cycle, or halt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= '0;
      sp      <= '0;
      arg     <= '0;
      inst    <= '0;
      err     <= 1'b0;
      strobes <= '0;
    end else begin
      strobes <= '0;
      case (state)
        S_FETCH: begin
          if (prog_mem_valid) begin
            inst <= prog_mem_data[3:0];
            pc   <= pc + ADDR_W'(1);
            if (is_two_word(prog_mem_data[3:0])) begin
              state <= S_FETCH_ARG;
            end else begin
              state   <= S_EXEC;
              strobes <= strobe_of(prog_mem_data[3:0]);
            end
          end
        end
        S_FETCH_ARG: begin
          if (prog_mem_valid) begin
            arg     <= prog_mem_data;
            pc      <= pc + ADDR_W'(1);
            state   <= S_EXEC;
            strobes <= strobe_of(inst);
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (inst)
            OP_HLT: state <= S_HALT;
            OP_JMP: pc <= arg[ADDR_W-1:0];
            OP_JMZ: begin
              if (alu_is_zero) pc <= arg[ADDR_W-1:0];
            end
            OP_CALL: begin
              if (sp == SP_FULL) begin
                err   <= 1'b1;
                state <= S_HALT;
              end else begin
                sp <= sp + SP_W'(1);
                pc <= arg[ADDR_W-1:0];
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                err   <= 1'b1;
                state <= S_HALT;
              end else begin
                sp <= sp_dec;
                pc <= stack[pop_idx];
              end
            end
            4'hE, 4'hF: begin
              err   <= 1'b1;
              state <= S_HALT;
            end
            default: ;
          endcase
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Return-address push; contents are deliberately left unreset, only sp is cleared
  always_ff @(posedge clk) begin
    if (reset && (state == S_EXEC) && (inst == OP_CALL) && (sp != SP_FULL)) begin
      stack[push_idx] <= pc;
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: scoreboard bench. An instruction-level reference model
// produces the expected fetch addresses and strobes. A monitor compares them
// against what the DUT presents on its ports.
module tb_seq_control_unit;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              prog_mem_req;
  logic [ADDR_W-1:0] prog_mem_addr;
  logic              prog_mem_valid = 1'b0;
  logic [WIDTH-1:0]  prog_mem_data = '0;
  logic [WIDTH-1:0]  arg;
  logic              alu_is_zero = 1'b0;
  logic              ctl_hlt, ctl_arg, ctl_nad, ctl_shl, ctl_shr;
  logic              ctl_acc, ctl_out, ctl_read, ctl_write;
  logic              halted, err;
  logic [8:0]        vec;

  typedef struct {
    bit          is_strobe;
    logic [15:0] val;
    logic [15:0] argv;
    int          cyc;
  } ev_t;

  ev_t         sb [$];
  logic [15:0] mem [0:MEM_SZ-1];
  int          asserts = 0;
  int          failures = 0;
  bit          checking = 0;
  bit          zero_wait = 0;
  bit          exp_halt = 0;
  bit          exp_err = 0;
  int          wait_min = 0;
  int          wait_max = 0;

  seq_control_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .prog_mem_req(prog_mem_req), .prog_mem_addr(prog_mem_addr),
    .prog_mem_valid(prog_mem_valid), .prog_mem_data(prog_mem_data),
    .arg(arg), .alu_is_zero(alu_is_zero),
    .ctl_hlt(ctl_hlt), .ctl_arg(ctl_arg), .ctl_nad(ctl_nad), .ctl_shl(ctl_shl),
    .ctl_shr(ctl_shr), .ctl_acc(ctl_acc), .ctl_out(ctl_out), .ctl_read(ctl_read),
    .ctl_write(ctl_write), .halted(halted), .err(err)
  );

  assign vec = {ctl_hlt, ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_acc, ctl_out, ctl_read, ctl_write};

  // Free-running clock
  always #5 clk = ~clk;

  // Overall time limit so the run cannot hang
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Program memory responder with a configurable number of wait states
  initial begin
    int  wait_cnt = 0;
    int  target = 0;
    bit  offered = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prog_mem_valid = 1'b0;
        wait_cnt = 0;
        offered = 0;
        target = $urandom_range(wait_max, wait_min);
      end else begin
        if (offered) begin
          wait_cnt = 0;
          target = $urandom_range(wait_max, wait_min);
          offered = 0;
        end
        if (prog_mem_req && wait_cnt >= target) begin
          prog_mem_valid = 1'b1;
          prog_mem_data = mem[prog_mem_addr];
          offered = 1;
        end else begin
          if (prog_mem_req) wait_cnt++;
          prog_mem_valid = !prog_mem_req && ($urandom_range(1, 0) == 1);
          prog_mem_data = 16'($urandom);
        end
      end
    end
  end

  // Pop one expected event and compare it with what the DUT just presented
  task automatic check_output(input bit is_strobe, input logic [15:0] val, input int cyc);
    ev_t e;
    asserts++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event: got %s 0x%0h at cycle %0d, required no event",
               is_strobe ? "strobe" : "fetch", val, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.is_strobe != is_strobe || e.val !== val) begin
      failures++;
      $display("[TB] FAIL event: got %s 0x%0h, required %s 0x%0h",
               is_strobe ? "strobe" : "fetch", val, e.is_strobe ? "strobe" : "fetch", e.val);
    end
    if (is_strobe && e.is_strobe) begin
      asserts++;
      if (arg !== e.argv) begin
        failures++;
        $display("[TB] FAIL arg: got 0x%0h, required 0x%0h", arg, e.argv);
      end
    end
    if (zero_wait) begin
      asserts++;
      if (cyc != e.cyc) begin
        failures++;
        $display("[TB] FAIL latency: event at cycle %0d, required cycle %0d", cyc, e.cyc);
      end
    end
  endtask

  // Monitor: sample away from the clock edge, check handshakes and strobes
  initial begin
    int           cyc = 0;
    bit           prev_wait = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        cyc = 0;
        prev_wait = 0;
      end else begin
        cyc++;
        if (checking) begin
          if (prev_wait) begin
            asserts++;
            if (prog_mem_req !== 1'b1 || prog_mem_addr !== prev_addr) begin
              failures++;
              $display("[TB] FAIL stable_wait: got req=%0b addr=0x%0h, required req=1 addr=0x%0h",
                       prog_mem_req, prog_mem_addr, prev_addr);
            end
          end
          if (prog_mem_req && prog_mem_valid) check_output(1'b0, 16'(prog_mem_addr), cyc);
          if (vec != '0) check_output(1'b1, 16'(vec), cyc);
        end
        prev_wait = prog_mem_req && !prog_mem_valid;
        prev_addr = prog_mem_addr;
      end
    end
  end

  // Instruction-level reference: walk the program and list the observable events
  task automatic build_model(input bit zero, input int steps);
    int          pc = 0;
    int          c = 0;
    int          stk [$];
    logic [15:0] argv = '0;
    logic [3:0]  op;
    ev_t         e;
    exp_halt = 0;
    exp_err = 0;
    for (int n = 0; n < steps && !exp_halt; n++) begin
      op = mem[pc][3:0];
      c++;
      e = '{is_strobe: 1'b0, val: 16'(pc), argv: '0, cyc: c};
      sb.push_back(e);
      pc = (pc + 1) % MEM_SZ;
      if (op == 2 || op == 8 || op == 9 || op == 10 || op == 11 || op == 12) begin
        c++;
        e = '{is_strobe: 1'b0, val: 16'(pc), argv: '0, cyc: c};
        sb.push_back(e);
        argv = mem[pc];
        pc = (pc + 1) % MEM_SZ;
      end
      c++;
      if (op >= 1 && op <= 9) begin
        e = '{is_strobe: 1'b1, val: 16'(1) << (9 - op), argv: argv, cyc: c};
        sb.push_back(e);
      end
      case (op)
        4'd1:  exp_halt = 1;
        4'd10: pc = argv % MEM_SZ;
        4'd11: if (zero) pc = argv % MEM_SZ;
        4'd12: begin
          if (stk.size() == DEPTH) begin
            exp_halt = 1;
            exp_err = 1;
          end else begin
            stk.push_back(pc);
            pc = argv % MEM_SZ;
          end
        end
        4'd13: begin
          if (stk.size() == 0) begin
            exp_halt = 1;
            exp_err = 1;
          end else begin
            pc = stk.pop_back();
          end
        end
        4'd14, 4'd15: begin
          exp_halt = 1;
          exp_err = 1;
        end
        default: ;
      endcase
    end
  endtask

  // Reset the DUT, prepare expectations and release reset just after a rising edge
  task automatic apply_stimulus(input int wmin, input int wmax, input bit zero, input int steps);
    reset = 1'b0;
    checking = 0;
    sb.delete();
    alu_is_zero = zero;
    wait_min = wmin;
    wait_max = wmax;
    zero_wait = (wmax == 0);
    repeat (2) @(posedge clk);
    build_model(zero, steps);
    @(posedge clk);
    #2;
    reset = 1'b1;
    checking = 1;
  endtask

  // Wait for all expected events, then check the final halted/err status
  task automatic finish_run(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && (!exp_halt || halted)) break;
    end
    asserts++;
    if (n >= 3000) begin
      failures++;
      $display("[TB] FAIL %s_timeout: %0d events pending halted=%0b, required 0 pending", name, sb.size(), halted);
    end
    if (exp_halt) begin
      repeat (4) @(negedge clk);
      #2;
      asserts++;
      if (halted !== 1'b1 || prog_mem_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_halted: got halted=%0b req=%0b, required halted=1 req=0", name, halted, prog_mem_req);
      end
    end
    asserts++;
    if (err !== exp_err) begin
      failures++;
      $display("[TB] FAIL %s_err: got %0b, required %0b", name, err, exp_err);
    end
    checking = 0;
  endtask

  task automatic run_program(input string name, input int wmin, input int wmax, input bit zero, input int steps);
    apply_stimulus(wmin, wmax, zero, steps);
    finish_run(name);
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 16'h0001;
  endtask

  initial begin
    int n;
    fill_hlt();
    wait_min = 0;
    wait_max = 0;

    // reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    asserts++;
    if (vec !== '0 || halted !== 1'b0 || err !== 1'b0 || arg !== '0 ||
        prog_mem_addr !== '0 || prog_mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_state: got ctl=0x%0h halted=%0b err=%0b arg=0x%0h addr=0x%0h req=%0b, required 0/0/0/0/0/1",
               vec, halted, err, arg, prog_mem_addr, prog_mem_req);
    end

    // zero-wait sequence with cycle-exact strobes
    fill_hlt();
    mem[0] = 16'h0002; mem[1] = 16'h1234; mem[2] = 16'h0006; mem[3] = 16'h0001;
    run_program("t1", 0, 0, 1'b0, 10);

    // same program with three wait states per fetch
    run_program("t2", 3, 3, 1'b0, 10);

    // conditional jump taken and not taken
    fill_hlt();
    mem[0] = 16'h000B; mem[1] = 16'h0010;
    run_program("t3_zero", 0, 0, 1'b1, 10);
    run_program("t3_nonzero", 0, 2, 1'b0, 10);

    // call/return, then a RET on an empty stack
    fill_hlt();
    mem[0] = 16'h000C; mem[1] = 16'h0020; mem[16'h20] = 16'h000D; mem[2] = 16'h000D;
    run_program("t4_callret", 0, 1, 1'b0, 10);

    // recursive CALL overflows the stack
    fill_hlt();
    mem[0] = 16'h000C; mem[1] = 16'h0000;
    run_program("t4_overflow", 0, 2, 1'b0, 20);

    // immediate RET underflow and illegal opcodes, upper bits ignored
    fill_hlt();
    mem[0] = 16'h000D;
    run_program("t5_ret", 0, 0, 1'b0, 5);
    mem[0] = 16'h000E;
    run_program("t5_illegal", 0, 1, 1'b0, 5);
    mem[0] = 16'hABC6; mem[1] = 16'h55FF;
    run_program("t5_upper", 0, 0, 1'b0, 5);

    // address wrap, including an argument fetched across the wrap
    fill_hlt();
    mem[0] = 16'h000A; mem[1] = 16'h12FE; mem[8'hFE] = 16'h0000; mem[8'hFF] = 16'h0002;
    run_program("t6_wrap", 0, 0, 1'b0, 10);

    // reset during the execute cycle drops the strobe asynchronously
    fill_hlt();
    mem[0] = 16'h0006;
    apply_stimulus(0, 0, 1'b0, 1);
    for (n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (ctl_acc) break;
    end
    asserts++;
    if (n >= 20) begin
      failures++;
      $display("[TB] FAIL t6_acc_wait: ctl_acc=%0b, required 1 within 20 cycles", ctl_acc);
    end
    checking = 0;
    reset = 1'b0;
    #1;
    asserts++;
    if (vec !== '0 || halted !== 1'b0 || prog_mem_req !== 1'b1 || prog_mem_addr !== '0) begin
      failures++;
      $display("[TB] FAIL t6_async_reset: got ctl=0x%0h halted=%0b req=%0b addr=0x%0h, required 0/0/1/0",
               vec, halted, prog_mem_req, prog_mem_addr);
    end
    sb.delete();
    mem[1] = 16'h0003;
    run_program("t6_after_reset", 0, 0, 1'b0, 5);

    // randomized programs against the reference model
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < MEM_SZ; i++) begin
        int op;
        op = $urandom_range(15, 0);
        if (op >= 14 && $urandom_range(3, 0) != 0) op = 0;
        if (op == 1 && $urandom_range(1, 0) != 0) op = 3;
        mem[i] = {12'($urandom), 4'(op)};
      end
      run_program("random", 0, (r % 2 == 0) ? 0 : 3, 1'($urandom_range(1, 0)), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
